// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S audio transmitter.
`timescale 1ns/1ps
package audio_pkg;
  localparam int CLK_FREQ       = 50_000_000;
  localparam int BITS_PER_FRAME = 64;
  localparam int MAX_SAMPLE_W   = 32;

  typedef logic signed [MAX_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_t;
endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: owns div_cnt and bclk, flags the cycle that ends with bclk falling.
`timescale 1ns/1ps
module audio_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_run,
  output logic o_bclk,
  output logic o_fall_edge
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_bclk;
  logic       w_wrap;

  assign w_wrap = (r_div_cnt == DIV_LAST);

  // Start preloads bclk high so the very first toggle is a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (i_start) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b1;
    end else if (i_run) begin
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
    end else begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end
  end

  assign o_bclk      = r_bclk;
  assign o_fall_edge = i_run && r_bclk && w_wrap;
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: frames two sample channels into a 64-bclk frame with one-bit delay.
`timescale 1ns/1ps
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV      = 8,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] left_data,
  input  logic [SAMPLE_WIDTH-1:0] right_data,
  input  logic                    left_valid,
  input  logic                    right_valid,
  output logic                    left_ready,
  output logic                    right_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    dacdat,
  output logic                    underflow
);
  localparam logic [5:0] FRAME_LAST = 6'(BITS_PER_FRAME - 1);

  i2s_state_t              r_state;
  logic [5:0]              r_bit_cnt;
  logic                    r_lrclk;
  logic                    r_dacdat;
  logic                    r_underflow;
  logic [SAMPLE_WIDTH-1:0] r_left;
  logic [SAMPLE_WIDTH-1:0] r_right;

  logic       w_start;
  logic       w_run;
  logic       w_bclk;
  logic       w_fall;
  logic       w_frame_end;
  logic       w_load;
  logic [5:0] w_bit_nxt;

  // Slot position p carries sample bit SAMPLE_WIDTH-p; position 0 and the tail are padding.
  function automatic logic f_slot_bit(input logic [SAMPLE_WIDTH-1:0] s, input logic [4:0] p);
    logic [SAMPLE_WIDTH-1:0] sh;
    logic                    b;
    b = 1'b0;
    if (p != 5'd0 && int'(p) <= SAMPLE_WIDTH) begin
      sh = s >> (SAMPLE_WIDTH - int'(p));
      b  = sh[0];
    end
    return b;
  endfunction

  audio_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_run      (w_run),
    .o_bclk     (w_bclk),
    .o_fall_edge(w_fall)
  );

  assign w_start     = (r_state == ST_IDLE) && enable;
  assign w_run       = (r_state != ST_IDLE);
  assign w_frame_end = w_fall && (r_bit_cnt == FRAME_LAST);
  assign w_load      = (r_state == ST_RUN) && w_frame_end;
  assign w_bit_nxt   = r_bit_cnt + 6'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= FRAME_LAST;
      r_lrclk     <= 1'b0;
      r_dacdat    <= 1'b0;
      r_underflow <= 1'b0;
      r_left      <= '0;
      r_right     <= '0;
    end else begin
      r_underflow <= w_load && !(left_valid && right_valid);
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= FRAME_LAST;
          r_lrclk   <= 1'b0;
          r_dacdat  <= 1'b0;
          if (enable) r_state <= ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (r_state == ST_RUN && !enable)      r_state <= ST_DRAIN;
          else if (r_state == ST_DRAIN && enable) r_state <= ST_RUN;
          // A draining frame ends on its final fall edge without loading new samples.
          if (r_state == ST_DRAIN && w_frame_end) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= FRAME_LAST;
            r_lrclk   <= 1'b0;
            r_dacdat  <= 1'b0;
          end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrclk   <= w_bit_nxt[5];
            r_dacdat  <= f_slot_bit(w_bit_nxt[5] ? r_right : r_left, w_bit_nxt[4:0]);
            if (w_load) begin
              r_left  <= left_valid  ? left_data  : '0;
              r_right <= right_valid ? right_data : '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bclk        = w_bclk;
  assign lrclk       = r_lrclk;
  assign dacdat      = r_dacdat;
  assign left_ready  = w_load;
  assign right_ready = w_load;
  assign underflow   = r_underflow;
endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 8, meaning clk cycles per bclk half-period (legal 2..255).
REQ-002 Parameter SAMPLE_WIDTH, default 16, meaning sample bits per channel (legal 8..32).
REQ-003 Ports: clk  in  1  system clock, 50 MHz.
REQ-004 Ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: enable  in  1  run request, level-sensitive.
REQ-006 Ports: left_data / right_data  in  SAMPLE_WIDTH  two's-complement samples from the channel FIFOs.
REQ-007 Ports: left_valid / right_valid  in  1  sample available.
REQ-008 Ports: left_ready / right_ready  out  1  sample accepted this cycle.
REQ-009 Ports: bclk, lrclk, dacdat  out  1 each  I2S master outputs to codec DAC.
REQ-010 Ports: underflow  out  1  one-cycle pulse, missing sample at frame load.

Function
REQ-011 Divider: div_cnt counts 0..CLK_DIV-1; bclk SHALL toggle in the cycle div_cnt==CLK_DIV-1 while running; "fall edge" means bclk 1->0.
REQ-012 Frame: 64 bclk; bit_cnt (6 bits) SHALL increment on each fall edge, wrap 63->0.
REQ-013 lrclk SHALL equal bit_cnt[5], updated on the fall edge: 0 = left slot, 1 = right slot.
REQ-014 I2S one-bit delay: at slot position p = bit_cnt[4:0], dacdat SHALL be sample bit SAMPLE_WIDTH-p for p in 1..SAMPLE_WIDTH, else 0; dacdat changes only on fall edges.
REQ-015 Load point: the cycle whose fall edge moves bit_cnt 63->0; left_ready and right_ready SHALL be 1 in exactly that cycle, 0 otherwise.
REQ-016 Each channel SHALL capture its data at the load point iff its valid is 1; ready pulses regardless of valid.
REQ-017 A channel with valid=0 at the load point SHALL transmit all zeros for that frame; underflow SHALL pulse 1 the following cycle (once per frame even if both channels miss).
REQ-018 FSM states IDLE, RUN, DRAIN.
REQ-019 IDLE -> RUN when enable=1; on entry div_cnt=0, bit_cnt=63, bclk=1, so the first fall edge is a load point.
REQ-020 RUN -> DRAIN when enable=0; DRAIN completes the current frame, then enters IDLE at the 63->0 fall edge with no load (ready stays 0).
REQ-021 DRAIN -> RUN if enable returns to 1 before frame end, without interruption.
REQ-022 In IDLE, bclk, lrclk, dacdat, ready and underflow SHALL all be 0.
REQ-023 With CLK_DIV=8, bclk is 3.125 MHz and lrclk is 48.828 kHz (1024 clk per frame).
REQ-024 Samples captured are held unchanged for the whole frame; upstream changes to data mid-frame have no effect.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, div_cnt 0, bit_cnt 63, and bclk, lrclk, dacdat, left_ready, right_ready, underflow and the sample registers to 0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release with enable=1, operation restarts per REQ-019 on the next clk.

Structure
REQ-027 Package audio_pkg SHALL hold sample_t, CLK_FREQ (50e6), BITS_PER_FRAME (64) and the FSM state enum.
REQ-028 Sub-module audio_bclk_gen SHALL own div_cnt and bclk, and output a one-cycle fall_edge strobe; the top level owns the FSM, bit_cnt and shift registers.
REQ-029 No latches; all state is in a single clk domain.

Verification
REQ-030 reset_n=0 for 5 cycles with enable=1 -> every output 0 throughout; first ready pulse occurs CLK_DIV cycles after release.
REQ-031 enable=1, left 0x8001 and right 0x7FFE always valid -> bench decodes left 0x8001 and right 0x7FFE on bclk rising edges, every frame; lrclk period 1024 clk.
REQ-032 right_valid=0 at one load point -> right slot all zeros, left correct, underflow high exactly 1 cycle, right_ready still pulses.
REQ-033 enable dropped at bit_cnt 20 -> frame completes, no further ready pulses, then all outputs 0 after the 63->0 edge.
REQ-034 reset_n pulsed at bit_cnt 40 -> outputs 0 immediately (same cycle); after release the next frame carries the then-valid samples.
REQ-035 Run 10 frames -> exactly 10 ready pulses per channel, spaced 1024 clk apart, and no underflow.
